uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter LOG2D, default 4, giving FIFO depth D = 2^LOG2D entries.
REQ-002 SHALL have parameter W, default 8, giving the entry width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port rdyRx, input, 1 bit: upstream receiver holds a byte; stays high until acknowledged.
REQ-006 SHALL have port dataRx, input, W bits: upstream byte, valid while rdyRx=1.
REQ-007 SHALL have port doneRx, output, 1 bit: one-cycle acknowledge to the upstream receiver.
REQ-008 SHALL have port pop, input, 1 bit: one-cycle CPU read strobe, decoded IO read of the data register.
REQ-009 SHALL have port clr, input, 1 bit: synchronous flush.
REQ-010 SHALL have port data, output, W bits: head entry.
REQ-011 SHALL have port rdy, output, 1 bit: FIFO non-empty.
REQ-012 SHALL have port count, output, LOG2D+1 bits: current occupancy, 0..D.
REQ-013 SHALL have port ovf, output, 1 bit: sticky overflow flag.

Function
REQ-014 SHALL use a two-state capture FSM, WAIT and ACK; it leaves reset in WAIT.
REQ-015 In WAIT with rdyRx=1, the block SHALL capture dataRx at that edge and move to ACK.
REQ-016 In WAIT with rdyRx=0, the block SHALL stay in WAIT.
REQ-017 In ACK, the block SHALL return to WAIT unconditionally; it captures nothing in ACK.
REQ-018 doneRx SHALL be registered and SHALL be 1 exactly while the FSM is in ACK: a one-cycle pulse per captured byte.
REQ-019 Each byte SHALL be captured at most once; minimum spacing between captures is 2 cycles.
REQ-020 Capture when count<D, or when count=D with pop=1 in the same cycle, SHALL write mem[wp], increment wp modulo D and leave ovf unchanged.
REQ-021 Capture when count=D with pop=0 SHALL drop the byte and set ovf=1; doneRx is still pulsed, so the receiver is released.
REQ-022 pop=1 with count>0 SHALL increment rp modulo D.
REQ-023 pop=1 with count=0 SHALL be ignored: no pointer or count change, no error.
REQ-024 count SHALL update as +1 for accepted push only, -1 for effective pop only, and stay unchanged for both or neither.
REQ-025 rdy SHALL equal (count != 0), combinational from registered count.
REQ-026 data SHALL equal mem[rp], combinational read.
REQ-027 data SHALL be valid whenever rdy=1 and SHALL be don't-care when rdy=0.
REQ-028 A pushed byte SHALL be visible on data/rdy in the cycle after its capture edge.
REQ-029 Pointers SHALL wrap from D-1 to 0 without affecting data order (strict FIFO).
REQ-030 clr=1 SHALL, at the edge, set wp=rp=0, count=0 and ovf=0, overriding any push or pop in that cycle.
REQ-031 clr SHALL NOT alter FSM state, so a byte arriving during clr is still acknowledged and is discarded.
REQ-032 ovf SHALL clear only via clr or rst; pop does not clear it.
REQ-033 Memory contents SHALL need no reset.

Reset
REQ-034 rst=0 SHALL immediately, without a clock, force FSM=WAIT, doneRx=0, wp=0, rp=0, count=0, ovf=0 and rdy=0.
REQ-035 rst asserted mid-ACK SHALL abort the pulse (doneRx=0 at once) and drop no state other than the FIFO contents.
REQ-036 After rst deasserts, the first capture SHALL occur on the first rising edge with rdyRx=1.

Verification
REQ-037 Single byte: rdyRx=1 with dataRx=8'h41 for 1 cycle, then drop on doneRx -> doneRx high exactly 1 cycle; next cycle rdy=1, data=8'h41, count=1; pop pulse -> rdy=0, count=0.
REQ-038 Fill and overflow (LOG2D=4): push 17 bytes 8'h00..8'h10 with no pops -> count=16, ovf=1, 17 doneRx pulses; 16 pops read 8'h00..8'h0F in order.
REQ-039 Wrap and simultaneous: push 10, pop 10, push 12 (wp wraps past 15) -> order preserved; with count=16, push plus pop in the same cycle -> count stays 16, ovf stays 0.
REQ-040 Empty pop and clr: pop with count=0 -> no change; count=5, ovf=1, clr=1 coincident with push -> count=0, ovf=0, doneRx still pulses.
REQ-041 Async reset: assert rst=0 between clock edges during ACK with count=3 -> doneRx, count, rdy and ovf all 0 before the next edge; after release, a normal capture works.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte FIFO sitting between a UART receiver and a CPU.
// A two-state capture FSM (WAIT/ACK) takes one byte per rdyRx handshake and
// acknowledges it with a one-cycle doneRx pulse. Bytes are queued in a 2^LOG2D
// entry FIFO that the CPU drains with pop strobes. A byte that arrives while
// the FIFO is full, with no pop in the same cycle, is dropped and sets the
// sticky ovf flag.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-low reset
//   rdyRx   in   receiver holds a byte (level, held until doneRx)
//   dataRx  in   W   receiver byte
//   doneRx  out  one-cycle acknowledge to the receiver
//   pop     in   CPU read strobe, removes the head entry
//   clr     in   synchronous flush (pointers, count, ovf)
//   data    out  W   head entry (valid while rdy=1)
//   rdy     out  FIFO non-empty
//   count   out  LOG2D+1   occupancy 0..2^LOG2D
//   ovf     out  sticky overflow flag
module uart_rx_fifo #(
  parameter int unsigned LOG2D = 4,
  parameter int unsigned W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdyRx,
  input  logic [W-1:0]     dataRx,
  output logic             doneRx,
  input  logic             pop,
  input  logic             clr,
  output logic [W-1:0]     data,
  output logic             rdy,
  output logic [LOG2D:0]   count,
  output logic             ovf
);

  localparam int unsigned   D    = 1 << LOG2D;
  localparam logic [LOG2D:0] FULL = {1'b1, {LOG2D{1'b0}}};

  typedef enum logic {
    WAIT = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             capture;
  logic [LOG2D-1:0] wp;
  logic [LOG2D-1:0] rp;
  logic [W-1:0]     mem [D];

  logic full;
  logic empty;
  logic do_push;
  logic do_pop;
  logic drop;

  // Capture FSM: one capture per visit to WAIT, so bytes are at least two
  // cycles apart and a held rdyRx is never sampled twice for the same byte.
  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    case (state)
      WAIT: begin
        if (rdyRx) begin
          capture  = 1'b1;
          state_nx = ACK;
        end
      end
      ACK:     state_nx = WAIT;
      default: state_nx = WAIT;
    endcase
  end

  // clr deliberately leaves the FSM alone so the receiver is still released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= WAIT;
      doneRx <= 1'b0;
    end else begin
      state  <= state_nx;
      doneRx <= (state_nx == ACK);
    end
  end

  assign full    = (count == FULL);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a byte when the same edge frees a slot.
  assign do_push = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) ovf <= 1'b1;
    end
  end

  // Storage needs no reset; unread entries are don't-care.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wp] <= dataRx;
  end

  assign data = mem[rp];
  assign rdy  = (count != '0);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo (LOG2D=4, W=8). Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst;
  logic       rdyRx;
  logic [7:0] dataRx;
  logic       doneRx;
  logic       pop;
  logic       clr;
  logic [7:0] data;
  logic       rdy;
  logic [4:0] count;
  logic       ovf;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_fifo #(.LOG2D(4), .W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .rdyRx  (rdyRx),
    .dataRx (dataRx),
    .doneRx (doneRx),
    .pop    (pop),
    .clr    (clr),
    .data   (data),
    .rdy    (rdy),
    .count  (count),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // Receiver handshake: present a byte, release rdyRx after one cycle.
  // ack = doneRx one cycle after presenting, late = doneRx one cycle later.
  task automatic push_byte(input logic [7:0] b, input logic with_pop,
                           input logic with_clr, output logic ack,
                           output logic late);
    @(negedge clk);
    rdyRx  = 1'b1;
    dataRx = b;
    pop    = with_pop;
    clr    = with_clr;
    @(negedge clk);
    ack   = doneRx;
    rdyRx = 1'b0;
    pop   = 1'b0;
    clr   = 1'b0;
    @(negedge clk);
    late = doneRx;
  endtask

  task automatic pop_byte();
    @(negedge clk);
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; rdyRx = 1'b0; dataRx = '0; pop = 1'b0; clr = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({doneRx, rdy, count, ovf} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got done=%b rdy=%b count=%0d ovf=%b expected all 0",
               doneRx, rdy, count, ovf);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    logic ack, late;
    push_byte(8'h41, 1'b0, 1'b0, ack, late);
    n_tests++;
    if (ack !== 1'b1 || late !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pulse: got ack=%b late=%b expected ack=1 late=0", ack, late);
    end
    n_tests++;
    if (rdy !== 1'b1 || data !== 8'h41 || count !== 5'd1) begin
      n_fail++;
      $display("FAIL single_visible: got rdy=%b data=%h count=%0d expected rdy=1 data=41 count=1",
               rdy, data, count);
    end
    pop_byte();
    n_tests++;
    if (rdy !== 1'b0 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL single_pop: got rdy=%b count=%0d expected rdy=0 count=0", rdy, count);
    end
  endtask

  task automatic test_fill_overflow();
    logic ack, late;
    int   pulses = 0;
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i), 1'b0, 1'b0, ack, late);
      if (ack === 1'b1 && late === 1'b0) pulses++;
    end
    n_tests++;
    if (count !== 5'd16 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_16: got count=%0d ovf=%b expected count=16 ovf=0", count, ovf);
    end
    push_byte(8'h10, 1'b0, 1'b0, ack, late);
    if (ack === 1'b1 && late === 1'b0) pulses++;
    n_tests++;
    if (count !== 5'd16 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_17: got count=%0d ovf=%b expected count=16 ovf=1", count, ovf);
    end
    n_tests++;
    if (pulses !== 17) begin
      n_fail++;
      $display("FAIL overflow_pulses: got %0d expected 17", pulses);
    end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (rdy !== 1'b1 || data !== 8'(i)) begin
        n_fail++;
        $display("FAIL fill_order[%0d]: got rdy=%b data=%h expected rdy=1 data=%h",
                 i, rdy, data, 8'(i));
      end
      pop_byte();
    end
    n_tests++;
    if (count !== 5'd0 || rdy !== 1'b0 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL drained_ovf_sticky: got count=%0d rdy=%b ovf=%b expected 0 0 1",
               count, rdy, ovf);
    end
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    n_tests++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_ovf: got ovf=%b expected 0", ovf);
    end
  endtask

  task automatic test_wrap_simul();
    logic ack, late;
    for (int i = 0; i < 10; i++) push_byte(8'h20 + 8'(i), 1'b0, 1'b0, ack, late);
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (data !== 8'h20 + 8'(i)) begin
        n_fail++;
        $display("FAIL wrap_first[%0d]: got %h expected %h", i, data, 8'h20 + 8'(i));
      end
      pop_byte();
    end
    // wp/rp now at 10; the next 12 pushes cross index 15 -> 0.
    for (int i = 0; i < 12; i++) push_byte(8'h30 + 8'(i), 1'b0, 1'b0, ack, late);
    n_tests++;
    if (count !== 5'd12) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d expected 12", count);
    end
    for (int i = 0; i < 12; i++) begin
      n_tests++;
      if (data !== 8'h30 + 8'(i)) begin
        n_fail++;
        $display("FAIL wrap_order[%0d]: got %h expected %h", i, data, 8'h30 + 8'(i));
      end
      pop_byte();
    end
    for (int i = 0; i < 16; i++) push_byte(8'h50 + 8'(i), 1'b0, 1'b0, ack, late);
    push_byte(8'h66, 1'b1, 1'b0, ack, late);
    n_tests++;
    if (ack !== 1'b1 || count !== 5'd16 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL full_push_pop: got ack=%b count=%0d ovf=%b expected 1 16 0",
               ack, count, ovf);
    end
    for (int i = 1; i < 17; i++) begin
      logic [7:0] exp;
      exp = (i == 16) ? 8'h66 : 8'h50 + 8'(i);
      n_tests++;
      if (data !== exp) begin
        n_fail++;
        $display("FAIL simul_order[%0d]: got %h expected %h", i, data, exp);
      end
      pop_byte();
    end
    n_tests++;
    if (count !== 5'd0) begin
      n_fail++;
      $display("FAIL simul_drain: got count=%0d expected 0", count);
    end
  endtask

  task automatic test_empty_pop_clr();
    logic ack, late;
    pop_byte();
    n_tests++;
    if (count !== 5'd0 || rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_pop: got count=%0d rdy=%b expected 0 0", count, rdy);
    end
    push_byte(8'h77, 1'b0, 1'b0, ack, late);
    n_tests++;
    if (data !== 8'h77 || count !== 5'd1) begin
      n_fail++;
      $display("FAIL empty_pop_ptr: got data=%h count=%0d expected 77 1", data, count);
    end
    pop_byte();
    for (int i = 0; i < 17; i++) push_byte(8'h80 + 8'(i), 1'b0, 1'b0, ack, late);
    for (int i = 0; i < 11; i++) pop_byte();
    n_tests++;
    if (count !== 5'd5 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_clr: got count=%0d ovf=%b expected 5 1", count, ovf);
    end
    push_byte(8'hEE, 1'b0, 1'b1, ack, late);
    n_tests++;
    if (ack !== 1'b1 || count !== 5'd0 || ovf !== 1'b0 || rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_with_push: got ack=%b count=%0d ovf=%b rdy=%b expected 1 0 0 0",
               ack, count, ovf, rdy);
    end
    push_byte(8'h99, 1'b0, 1'b0, ack, late);
    n_tests++;
    if (data !== 8'h99 || count !== 5'd1) begin
      n_fail++;
      $display("FAIL after_clr: got data=%h count=%0d expected 99 1", data, count);
    end
    pop_byte();
  endtask

  task automatic test_async_reset();
    logic ack, late;
    for (int i = 0; i < 17; i++) push_byte(8'hC0 + 8'(i), 1'b0, 1'b0, ack, late);
    for (int i = 0; i < 14; i++) pop_byte();
    @(negedge clk);
    rdyRx  = 1'b1;
    dataRx = 8'hA3;
    @(posedge clk);
    #2;
    n_tests++;
    if (doneRx !== 1'b1 || count !== 5'd3 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_ack: got done=%b count=%0d ovf=%b expected 1 3 1",
               doneRx, count, ovf);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (doneRx !== 1'b0 || count !== 5'd0 || rdy !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got done=%b count=%0d rdy=%b ovf=%b expected all 0",
               doneRx, count, rdy, ovf);
    end
    @(negedge clk);
    rdyRx = 1'b0;
    rst   = 1'b1;
    push_byte(8'h5A, 1'b0, 1'b0, ack, late);
    n_tests++;
    if (ack !== 1'b1 || late !== 1'b0 || data !== 8'h5A || count !== 5'd1) begin
      n_fail++;
      $display("FAIL post_reset_capture: got ack=%b late=%b data=%h count=%0d expected 1 0 5a 1",
               ack, late, data, count);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_fill_overflow();
    test_wrap_simul();
    test_empty_pop_clr();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
